// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId registers, interrupt/exception request
// generation, and mfc0/mtc0/eret servicing for the M stage.
`timescale 1ns/1ps
module cp0 #(
  parameter logic [31:0] PRID = 32'h4D455445
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RAddr,
  input  logic [4:0]  WAddr,
  input  logic        WE,
  input  logic [31:0] Din,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcIn,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] Dout
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_raw;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req = (ExcIn != 5'd0) & ~exl_q;
  assign Req     = int_req | exc_req;
  assign epc_raw = BDIn ? (VPC - 32'd4) : VPC;

  assign sr_val    = {16'h0000, im_q, 8'h00, exl_q, ie_q};
  assign cause_val = {bd_q, 15'h0000, ip_q, 3'b000, exc_code_q, 2'b00};

  // Taking a request discards any coincident mtc0/eret; otherwise the mtc0
  // lands first and eret then overrides EXL.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (Req) begin
      exl_d      = 1'b1;
      bd_d       = BDIn;
      exc_code_d = int_req ? 5'd0 : ExcIn;
      epc_d      = {epc_raw[31:2], 2'b00};
    end else begin
      if (WE) begin
        case (WAddr)
          5'd12: begin
            im_d  = Din[15:10];
            exl_d = Din[1];
            ie_d  = Din[0];
          end
          5'd14:   epc_d = Din;
          default: ;
        endcase
      end
      if (EXLClr) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    Dout = '0;
    case (RAddr)
      5'd12:   Dout = sr_val;
      5'd13:   Dout = cause_val;
      5'd14:   Dout = epc_q;
      5'd15:   Dout = PRID;
      default: Dout = '0;
    endcase
  end

  assign EPCOut = epc_q;

endmodule
